// File: rtl/lane_dly_pkg.sv
// lane_dly_pkg: shared FSM states, command opcodes and response status codes for the lane delay sequencer.
package lane_dly_pkg;

    typedef enum logic [2:0] {IDLE, PAUSE, PULSE, GAP, HOLD, RESP} state_e;

    localparam logic OP_MOVE = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_OOR  = 2'b01;
    localparam logic [1:0] ST_ZERO = 2'b10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lane_dly_cycle_timer.sv
// lane_dly_cycle_timer: loadable down-counter timing the PAUSE/GAP/HOLD windows; done while the count is zero.
module lane_dly_cycle_timer
    import lane_dly_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_d  = load_i ? load_val_i : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    assign done_o = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/lane_dly_sequencer.sv
// lane_dly_sequencer: per-lane LANECTRL delay-line command sequencer wrapping each load/move in a clock-pause window.
// Optional LANE_DLY_TAP_TRACK_EN adds RX/TX tap position tracking with saturation abort.
module lane_dly_sequencer
    import lane_dly_pkg::*;
#(
    parameter int TAP_W        = 8,
    parameter int PAUSE_SETUP  = 2,
    parameter int PAUSE_HOLD   = 2,
    parameter int MOVE_GAP     = 4,
    parameter int LOAD_TAP_VAL = 1
) (
    input  logic             FAB_CLK,
    input  logic             RESET_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_OP,
    input  logic             CMD_SEL,
    input  logic             CMD_DIR,
    input  logic [TAP_W-1:0] CMD_TAPS,
    output logic             RSP_VALID,
    output logic [1:0]       RSP_STATUS,
    output logic [TAP_W-1:0] RSP_TAPS_DONE,
    output logic             BUSY,
    input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic             TX_DELAY_LINE_OUT_OF_RANGE,
    output logic             DELAY_LINE_SEL,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_MOVE,
    output logic             HS_IO_CLK_PAUSE
`ifdef LANE_DLY_TAP_TRACK_EN
    ,
    output logic [TAP_W-1:0] RX_TAP_POS,
    output logic [TAP_W-1:0] TX_TAP_POS
`endif
);

    localparam int CNT_W = $clog2(max3(PAUSE_SETUP, PAUSE_HOLD, MOVE_GAP)) + 1;
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(PAUSE_SETUP - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(MOVE_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(PAUSE_HOLD - 1);

    state_e           state_q, state_d;
    logic [1:0]       st_q, st_d;
    logic             op_q, sel_q, dir_q;
    logic [TAP_W-1:0] taps_q, done_q;
    logic             ready_q, busy_q, rsp_valid_q;
    logic [1:0]       rsp_status_q;
    logic [TAP_W-1:0] rsp_taps_q;
    logic             pause_q, move_q, load_q;
    logic             tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_val;
    logic             zero, oor, more, sat, go;

    lane_dly_cycle_timer #(.W(CNT_W)) u_timer (
        .clk_i      (FAB_CLK),
        .rst_ni     (RESET_N),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    assign zero = (CMD_OP == OP_MOVE) && (CMD_TAPS == '0);
    assign oor  = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
    assign more = (op_q == OP_MOVE) && (done_q < taps_q);
    assign go   = !oor && more && !sat;

`ifdef LANE_DLY_TAP_TRACK_EN
    logic [TAP_W-1:0] rx_pos_q, tx_pos_q, pos;

    assign pos        = sel_q ? tx_pos_q : rx_pos_q;
    // A pulse that would push the tracked position past either rail is never issued.
    assign sat        = (op_q == OP_MOVE) && (dir_q ? (&pos) : (pos == '0));
    assign RX_TAP_POS = rx_pos_q;
    assign TX_TAP_POS = tx_pos_q;

    always_ff @(posedge FAB_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_pos_q <= TAP_W'(LOAD_TAP_VAL);
            tx_pos_q <= TAP_W'(LOAD_TAP_VAL);
        end else if (state_q == PULSE) begin
            if (!sel_q) rx_pos_q <= (op_q == OP_LOAD) ? TAP_W'(LOAD_TAP_VAL) : dir_q ? rx_pos_q + 1'b1 : rx_pos_q - 1'b1;
            if (sel_q)  tx_pos_q <= (op_q == OP_LOAD) ? TAP_W'(LOAD_TAP_VAL) : dir_q ? tx_pos_q + 1'b1 : tx_pos_q - 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign sat        = 1'b0;
    assign unused_cfg = ^TAP_W'(LOAD_TAP_VAL);
`endif

    always_comb begin
        state_d  = state_q;
        st_d     = st_q;
        tmr_load = 1'b0;
        tmr_val  = HOLD_LD;
        case (state_q)
            IDLE: if (CMD_VALID) begin
                state_d  = zero ? RESP : PAUSE;
                st_d     = zero ? ST_ZERO : ST_OK;
                tmr_load = 1'b1;
                tmr_val  = SETUP_LD;
            end
            PAUSE: if (tmr_done) begin
                state_d  = sat ? HOLD : PULSE;
                st_d     = sat ? ST_OOR : ST_OK;
                tmr_load = sat;
            end
            PULSE: begin
                state_d  = GAP;
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
            end
            GAP: if (tmr_done) begin
                state_d  = go ? PULSE : HOLD;
                st_d     = (oor || (more && sat)) ? ST_OOR : ST_OK;
                tmr_load = !go;
            end
            HOLD:    state_d = tmr_done ? RESP : HOLD;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge FAB_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            st_q         <= ST_OK;
            op_q         <= OP_MOVE;
            sel_q        <= 1'b0;
            dir_q        <= 1'b0;
            taps_q       <= '0;
            done_q       <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_taps_q   <= '0;
            pause_q      <= 1'b0;
            move_q       <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            ready_q     <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            rsp_valid_q <= (state_d == RESP);
            pause_q     <= (state_d == PAUSE) || (state_d == PULSE) || (state_d == GAP) || (state_d == HOLD);
            move_q      <= (state_d == PULSE) && (op_q == OP_MOVE);
            load_q      <= (state_d == PULSE) && (op_q == OP_LOAD);
            if (state_q == IDLE && CMD_VALID) begin
                op_q   <= CMD_OP;
                sel_q  <= CMD_SEL;
                dir_q  <= CMD_DIR;
                taps_q <= CMD_TAPS;
                done_q <= '0;
            end else if (state_q == PULSE && op_q == OP_MOVE) begin
                done_q <= done_q + 1'b1;
            end
            if (state_d == RESP) begin
                rsp_status_q <= st_d;
                rsp_taps_q   <= (st_d == ST_ZERO) ? '0 : (op_q == OP_LOAD) ? TAP_W'(1) : done_q;
            end
        end
    end

    assign CMD_READY            = ready_q;
    assign BUSY                 = busy_q;
    assign RSP_VALID            = rsp_valid_q;
    assign RSP_STATUS           = rsp_status_q;
    assign RSP_TAPS_DONE        = rsp_taps_q;
    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign HS_IO_CLK_PAUSE      = pause_q;

endmodule
